// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: register map, CTRL field
// positions and the all-dark segment pattern.
package hex_display_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_BLINK = 2'd2;
    localparam logic [1:0] REG_SHIFT = 2'd3;

    localparam int BLANK_LSB = 0;
    localparam int BLINK_LSB = 8;
    localparam int EN_BIT    = 31;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_seg_decode.sv
// Nibble to active-low 7-segment pattern, bit order gfedcba.
module hex_seg_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        unique case (nibble_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM register block driving NUM_DIGITS active-low 7-segment displays.
// Blink support (timer, BLINK_DIV register, blink mask) is built only when HEX_BLINK_EN is defined.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int          NUM_DIGITS    = 6,
    parameter logic [31:0] BLINK_DIV_RST = 32'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    read,
    output logic [31:0]             readdata,
    input  logic                    write,
    input  logic [31:0]             writedata,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int DW = 4 * NUM_DIGITS;

    // Bus: no wait states. A write commits on the edge where write=1; a read
    // captures the pre-write register value on the edge where read=1 and holds it.
    logic [DW-1:0]           data_q, data_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    en_q, en_d;
    logic [31:0]             readdata_q, rd_mux;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d, seg_dec;
    logic                    phase;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [31:0]             div_rd;
    logic                    unused_ok;

    assign unused_ok = ^{writedata, BLINK_DIV_RST};

    always_comb begin
        data_d  = data_q;
        blank_d = blank_q;
        en_d    = en_q;
        if (write) begin
            case (address)
                REG_DATA:  data_d = writedata[DW-1:0];
                REG_CTRL: begin
                    blank_d = writedata[BLANK_LSB +: NUM_DIGITS];
                    en_d    = writedata[EN_BIT];
                end
                REG_SHIFT: data_d = DW'({data_q, writedata[3:0]});
                default: ;
            endcase
        end
    end

`ifdef HEX_BLINK_EN
    logic [31:0]           div_q, div_d, cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] blink_q, blink_d;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        blink_d = blink_q;
        if (write && address == REG_CTRL) begin
            blink_d = writedata[BLINK_LSB +: NUM_DIGITS];
        end
        // A BLINK_DIV write restarts the blink in the lit phase.
        if (write && address == REG_BLINK) begin
            div_d   = writedata;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= div_q - 32'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= BLINK_DIV_RST;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            blink_q <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    assign phase      = phase_q;
    assign blink_mask = blink_q;
    assign div_rd     = div_q;
`else
    assign phase      = 1'b0;
    assign blink_mask = '0;
    assign div_rd     = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_DATA, REG_SHIFT: rd_mux[DW-1:0] = data_q;
            REG_CTRL: begin
                rd_mux[BLANK_LSB +: NUM_DIGITS] = blank_q;
                rd_mux[BLINK_LSB +: NUM_DIGITS] = blink_mask;
                rd_mux[EN_BIT]                  = en_q;
            end
            REG_BLINK: rd_mux = div_rd;
            default: ;
        endcase
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        hex_seg_decode u_dec (
            .nibble_i (data_q[4*d +: 4]),
            .seg_o    (seg_dec[7*d +: 7])
        );
        assign hex_d[7*d +: 7] = (!en_q || blank_q[d] || (blink_mask[d] && phase))
                                 ? SEG_BLANK : seg_dec[7*d +: 7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            blank_q    <= '0;
            en_q       <= 1'b0;
            readdata_q <= '0;
            hex_q      <= '1;
        end else begin
            data_q  <= data_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            hex_q   <= hex_d;
            if (read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign readdata = readdata_q;
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed plus randomized bench for hex_display_ctrl against a cycle-indexed reference model.
module tb_hex_display_ctrl;

    localparam int          N       = 6;
    localparam logic [31:0] DIV_RST = 32'd0;
`ifdef HEX_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      address = 2'd0;
    logic            read = 1'b0;
    logic [31:0]     readdata;
    logic            write = 1'b0;
    logic [31:0]     writedata = 32'd0;
    logic [7*N-1:0]  hex_out;

    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV_RST(DIV_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .readdata  (readdata),
        .write     (write),
        .writedata (writedata),
        .hex_out   (hex_out)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus the edge count since reset and
    // the edge of the last BLINK_DIV write; the blink phase is derived arithmetically.
    logic [4*N-1:0] m_data;
    logic [N-1:0]   m_blank, m_blink;
    logic           m_en;
    logic [31:0]    m_div, m_rd;
    longint         m_edge, m_div_edge;
    logic [6:0]     seg_tab [16];
    int             n_cmp = 0;
    int             n_mis = 0;

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    function automatic logic ref_phase();
        if (m_div == 32'd0) return 1'b0;
        return logic'(((m_edge - m_div_edge) / longint'(m_div)) % 2);
    endfunction

    function automatic logic [7*N-1:0] ref_hex();
        logic [7*N-1:0] h;
        for (int d = 0; d < N; d++) begin
            if (!m_en || m_blank[d] || (m_blink[d] && ref_phase()))
                h[7*d +: 7] = 7'h7F;
            else
                h[7*d +: 7] = seg_tab[m_data[4*d +: 4]];
        end
        return h;
    endfunction

    function automatic logic [31:0] ref_reg(input logic [1:0] a);
        case (a)
            2'd0, 2'd3: return 32'(m_data);
            2'd1:       return {m_en, 15'd0, 8'(m_blink), 8'(m_blank)};
            default:    return m_div;
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0; m_blank = '0; m_blink = '0; m_en = 1'b0;
        m_div = BLINK_BUILT ? DIV_RST : 32'd0;
        m_rd = '0; m_edge = 0; m_div_edge = 0;
    endtask

    task automatic apply_write(input logic [1:0] a, input logic [31:0] wd);
        case (a)
            2'd0: m_data = wd[4*N-1:0];
            2'd1: begin
                m_blank = wd[N-1:0];
                m_blink = BLINK_BUILT ? wd[8 +: N] : '0;
                m_en    = wd[31];
            end
            2'd2: if (BLINK_BUILT) begin
                m_div      = wd;
                m_div_edge = m_edge;
            end
            default: m_data = (m_data << 4) | (4*N)'(wd[3:0]);
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle, starting and ending on a falling edge.
    task automatic bus(input logic wr, input logic rd, input logic [1:0] a, input logic [31:0] wd);
        logic [7*N-1:0] exp_hex;
        write = wr; read = rd; address = a; writedata = wd;
        exp_hex = ref_hex();
        if (rd) m_rd = ref_reg(a);
        @(posedge clk);
        m_edge++;
        if (wr) apply_write(a, wd);
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        check("hex_out", 64'(hex_out), 64'(exp_hex));
        check("readdata", 64'(readdata), 64'(m_rd));
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] wd;
        logic        wr, rd;

        model_reset();
        @(negedge clk);
        check("reset_hex", 64'(hex_out), {22'd0, {42{1'b1}}});
        check("reset_readdata", 64'(readdata), 64'd0);
        reset = 1'b0;

        bus(1'b1, 1'b0, 2'd1, 32'h8000_0000);
        bus(1'b1, 1'b0, 2'd0, 32'h0012_3456);
        idle(1);
        check("digit0_six", 64'(hex_out[6:0]), 64'(7'b0000010));
        check("digit5_one", 64'(hex_out[41:35]), 64'(7'b1111001));
        bus(1'b0, 1'b1, 2'd0, 32'd0);
        check("data_read", 64'(readdata), 64'h0012_3456);

        bus(1'b1, 1'b0, 2'd3, 32'h0000_000A);
        bus(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFB);
        bus(1'b0, 1'b1, 2'd3, 32'd0);
        check("shift_read", 64'(readdata), 64'h0034_56AB);
        check("digit0_b", 64'(hex_out[6:0]), 64'(7'b0000011));

        bus(1'b1, 1'b0, 2'd2, 32'd4);
        bus(1'b1, 1'b0, 2'd1, 32'h8000_0100);
        idle(18);
        bus(1'b1, 1'b0, 2'd2, 32'd4);
        idle(1);
        check("blink_restart_lit", 64'(hex_out[6:0]), 64'(7'b0000011));
        idle(9);
        bus(1'b1, 1'b0, 2'd2, 32'd1);
        idle(5);

        bus(1'b1, 1'b0, 2'd1, 32'h8000_0101);
        idle(10);
        check("blank_blink_dark", 64'(hex_out[6:0]), 64'h7F);

        bus(1'b1, 1'b1, 2'd0, 32'h00AB_CDEF);
        check("rw_same_cycle_old", 64'(readdata), 64'h0034_56AB);
        bus(1'b0, 1'b1, 2'd0, 32'd0);
        bus(1'b1, 1'b0, 2'd1, 32'h8000_FF3F);
        bus(1'b0, 1'b1, 2'd1, 32'd0);
        bus(1'b0, 1'b1, 2'd2, 32'd0);
        bus(1'b1, 1'b0, 2'd1, 32'h8000_0000);
        idle(2);

        repeat (300) begin
            a  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (a == 2'd2) wd = $urandom_range(0, 5);
            if (a == 2'd1) wd[31] = ($urandom_range(0, 3) != 0);
            bus(wr, rd, a, wd);
        end

        bus(1'b1, 1'b0, 2'd2, 32'd3);
        bus(1'b1, 1'b0, 2'd1, 32'h8000_3F00);
        bus(1'b1, 1'b0, 2'd3, 32'd9);
        idle(5);
        write = 1'b1; address = 2'd3; writedata = 32'd7;
        #2 reset = 1'b1;
        #1;
        check("async_reset_hex", 64'(hex_out), {22'd0, {42{1'b1}}});
        check("async_reset_readdata", 64'(readdata), 64'd0);
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        model_reset();
        reset = 1'b0;
        bus(1'b0, 1'b1, 2'd2, 32'd0);
        check("blink_div_after_reset", 64'(readdata), 64'(BLINK_BUILT ? DIV_RST : 32'd0));
        bus(1'b0, 1'b1, 2'd0, 32'd0);
        check("data_after_reset", 64'(readdata), 64'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
